// File: rtl/rmc_pkg.sv
// Shared types and default sizing for the read memory controller.
//   rmc_state_t    : controller FSM state
//   DEF_*          : default build sizes used as parameter defaults
//   FIFO_PTR_W     : response FIFO pointer width for the default depth
//   INFLIGHT_W     : width of the in-flight read counter for the default latency
package rmc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rmc_state_t;

    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_RD_LATENCY = 2;
    localparam int unsigned FIFO_PTR_W     = $clog2(DEF_FIFO_DEPTH);
    localparam int unsigned INFLIGHT_W     = $clog2(DEF_RD_LATENCY + 1);

endpackage

// File: rtl/rmc_resp_fifo.sv
// Response FIFO, first-word-fall-through. dout shows the head entry
// whenever the FIFO is non-empty and reads as zero when empty.
//   clk, rst : clock, asynchronous active-low reset
//   push/din : write din when not full
//   pop      : discard head entry when not empty
//   dout     : head entry
//   count    : number of valid entries (0..FIFO_DEPTH)
//   empty    : count == 0
//   full     : count == FIFO_DEPTH
module rmc_resp_fifo
    import rmc_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_SIZE-1:0]          din,
    output logic [DATA_SIZE-1:0]          dout,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          empty,
    output logic                          full
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/read_memory_controller.sv
// Burst read controller: accepts (addr, len) requests, issues sequential
// single-word reads to a fixed-latency memory, buffers returned words in a
// response FIFO and streams them out over valid/ready with a last flag.
//   clk, rst      : clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr/req_len : burst request handshake
//   read_en_out/address_out             : memory read strobe and address
//   mem_dataIn                          : read data, RD_LATENCY cycles after strobe
//   dataOut/out_valid/out_ready/out_last : response stream
//   busy                                : burst in progress
module read_memory_controller
    import rmc_pkg::*;
#(
    parameter int unsigned ADD_SIZE   = 11,
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned LEN_SIZE   = 8,
    parameter int unsigned RD_LATENCY = DEF_RD_LATENCY,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADD_SIZE-1:0]  req_addr,
    input  logic [LEN_SIZE-1:0]  req_len,
    output logic                 read_en_out,
    output logic [ADD_SIZE-1:0]  address_out,
    input  logic [DATA_SIZE-1:0] mem_dataIn,
    output logic [DATA_SIZE-1:0] dataOut,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned INF_W = $clog2(RD_LATENCY + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    rmc_state_t            state;
    logic [ADD_SIZE-1:0]   cur_addr;
    logic [ADD_SIZE-1:0]   last_addr;
    logic [LEN_SIZE-1:0]   issue_rem;
    logic [LEN_SIZE-1:0]   out_rem;
    logic [RD_LATENCY-1:0] pipe;
    logic [INF_W-1:0]      inflight;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  credit_ok;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + INF_W'(pipe[i]);
        end
    end

    // Every outstanding read owns a FIFO slot, so a returning word always
    // has room even if the consumer stalls indefinitely.
    assign credit_ok   = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);
    assign read_en_out = (state == ISSUE) && credit_ok;
    assign address_out = read_en_out ? cur_addr : last_addr;

    assign fifo_push = pipe[RD_LATENCY-1] && !fifo_full;
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign out_last  = out_valid && (out_rem == LEN_SIZE'(1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            cur_addr  <= '0;
            last_addr <= '0;
            issue_rem <= '0;
            out_rem   <= '0;
            pipe      <= '0;
        end else begin
            pipe[0] <= read_en_out;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end

            if (fifo_pop) begin
                out_rem <= out_rem - LEN_SIZE'(1);
            end

            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        cur_addr  <= req_addr;
                        issue_rem <= req_len;
                        out_rem   <= req_len;
                        if (req_len != '0) begin
                            state     <= ISSUE;
                            req_ready <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (read_en_out) begin
                        last_addr <= cur_addr;
                        cur_addr  <= cur_addr + ADD_SIZE'(1);
                        issue_rem <= issue_rem - LEN_SIZE'(1);
                        if (issue_rem == LEN_SIZE'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_pop && (out_rem == LEN_SIZE'(1))) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    rmc_resp_fifo #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (mem_dataIn),
        .dout  (dataOut),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: doc/read_memory_controller.md
Name: read_memory_controller

Overview:
- Reader-side counterpart of the output memory write controller. It accepts a burst read request (start address, word count) from the downstream consumer and issues sequential single-word reads to the output memory.
- Read data returns after a fixed memory latency. It is buffered in a small response FIFO and delivered over a valid/ready stream.
- Credit-based issue means no returned word is ever dropped when the consumer stalls.

Parameters:
- ADD_SIZE, 11, memory address width
- DATA_SIZE, 32, data word width
- LEN_SIZE, 8, burst length field width
- RD_LATENCY, 2, cycles from read_en_out asserted to valid mem_dataIn (>=1)
- FIFO_DEPTH, 4, response FIFO entries (power of 2, >= RD_LATENCY+1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  burst request present
- req_ready  out  1  controller can accept a request
- req_addr  in  ADD_SIZE  first word address
- req_len  in  LEN_SIZE  number of words to read
- read_en_out  out  1  one-cycle memory read strobe
- address_out  out  ADD_SIZE  memory read address
- mem_dataIn  in  DATA_SIZE  memory read data, valid RD_LATENCY cycles after strobe
- dataOut  out  DATA_SIZE  stream data to consumer
- out_valid  out  1  dataOut valid
- out_ready  in  1  consumer accepts word
- out_last  out  1  dataOut is final word of burst
- busy  out  1  burst in progress (state != IDLE)

Behaviour:
- Reset is asynchronous and active-low. While rst is low, all outputs are driven to 0, never z.
  - state=IDLE, FIFO empty, in-flight pipe cleared, counters 0.
  - req_ready rises to 1 on the first clock after rst deasserts.
- Reset mid-burst: the burst is abandoned, FIFO contents are discarded, and late mem_dataIn is ignored.
- Request handshake:
  - Transfer occurs when req_valid&&req_ready. req_ready=1 only in IDLE.
  - On transfer: latch cur_addr=req_addr, issue_rem=req_len, out_rem=req_len.
  - req_len==0: accepted, no reads issued, no stream output, state stays IDLE.
- States:
  - IDLE: on accepted nonzero request -> ISSUE.
  - ISSUE: read_en_out=1 in any cycle where (fifo_count + inflight) < FIFO_DEPTH.
    - In that cycle: address_out=cur_addr; cur_addr increments modulo 2^ADD_SIZE (0x7FF wraps to 0x000); issue_rem decrements.
    - When issue_rem reaches 0 -> DRAIN.
  - DRAIN: no reads issued. When out_rem reaches 0 (last word accepted) -> IDLE.
- Outside an issuing cycle, read_en_out=0 and address_out holds its last value.
- Return path:
  - An RD_LATENCY-deep valid shift register tracks in-flight reads.
  - When a tag exits the register, mem_dataIn is pushed into the FIFO in that cycle.
  - inflight = popcount of the shift register.
  - The credit rule guarantees a push never meets a full FIFO. An overflow is a design error; the bench asserts on it.
- Output stream:
  - out_valid = FIFO non-empty; dataOut = FIFO head (first-word-fall-through).
  - Pop on out_valid&&out_ready; out_rem decrements on each pop.
  - out_last = out_valid && (out_rem==1).
  - dataOut and out_last hold stable while out_valid&&!out_ready.
- Simultaneous push and pop in one cycle: fifo_count is unchanged and both operations take effect.
  - Push into an empty FIFO: the word appears on dataOut the next cycle.
- Latency: request accepted at edge N. First read_en_out at cycle N+1. First out_valid at cycle N+1+RD_LATENCY+1.
- Throughput: one word per cycle sustained when out_ready=1.
- Back-to-back bursts: a new request is accepted in the first IDLE cycle after the last pop.

Decomposition:
- Package rmc_pkg: state enum {IDLE, ISSUE, DRAIN}; localparam for FIFO pointer width = $clog2(FIFO_DEPTH); localparam for inflight width = $clog2(RD_LATENCY+1).
- Sub-module rmc_resp_fifo: parameterized DATA_SIZE/FIFO_DEPTH synchronous FIFO.
  - Ports: push, pop, din, dout, count, empty, full.
  - Asynchronous active-low reset.
- The FSM, issue counter and latency pipe stay in the top module.

Test Plan:
- Reset/basic: rst low then high; req addr=0x010, len=4; memory model returns data=addr+0x1000; out_ready=1.
  - Expect read_en_out on 4 consecutive cycles, addresses 0x010-0x013.
  - Expect stream 0x1010-0x1013 with out_last only on 0x1013; busy falls after the last pop.
- Backpressure: len=10, out_ready=0 for 20 cycles then 1.
  - Expect exactly FIFO_DEPTH=4 reads issued before stall; no lost or duplicated data.
  - Expect all 10 words delivered in order with out_last on the 10th.
- Address wrap: addr=0x7FE, len=4.
  - Expect address_out sequence 0x7FE, 0x7FF, 0x000, 0x001.
- Zero length and back-to-back: len=0 request, then immediately addr=0x100 len=1.
  - len=0: accepted, no read_en_out, no out_valid.
  - Second request: one read, one word with out_last=1.
- Reset mid-burst: len=8, assert rst after 3 words are delivered.
  - Expect all outputs 0 immediately.
  - After release: FIFO empty, req_ready=1, and a new len=2 burst completes correctly.
- Random out_ready toggling, RD_LATENCY=3 build, len=255.
  - Expect 255 in-order words, no FIFO overflow assertion, out_last once.
